// File: rtl/reaction_timer_bcd.sv
// Two-digit BCD reaction timer counting tenths of a second between start and stop,
// with saturation/overflow flag and a session best (lowest) time.
module reaction_timer_bcd #(
    parameter int unsigned MAX_TENS = 9,
    parameter int unsigned MAX_ONES = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       overflow,
    output logic [3:0] best_tens,
    output logic [3:0] best_ones,
    output logic       best_valid
);

    localparam int unsigned DIGIT_W  = 4;
    localparam int unsigned DIGIT_HI = 9;
    // Out-of-range parameters are clamped so digits always stay legal BCD.
    localparam int unsigned MAX_T_LIM = (MAX_TENS > DIGIT_HI) ? DIGIT_HI : MAX_TENS;
    localparam int unsigned MAX_O_LIM = (MAX_ONES > DIGIT_HI) ? DIGIT_HI : MAX_ONES;
    localparam logic [DIGIT_W-1:0] MAX_T  = DIGIT_W'(MAX_T_LIM);
    localparam logic [DIGIT_W-1:0] MAX_O  = DIGIT_W'(MAX_O_LIM);
    localparam logic [DIGIT_W-1:0] NINE   = DIGIT_W'(DIGIT_HI);
    localparam logic [DIGIT_W-1:0] ZERO   = DIGIT_W'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state_q;
    logic [DIGIT_W-1:0] tens_q;
    logic [DIGIT_W-1:0] ones_q;
    logic               running_q;
    logic               overflow_q;
    logic [DIGIT_W-1:0] best_tens_q;
    logic [DIGIT_W-1:0] best_ones_q;
    logic               best_valid_q;

    logic               at_max_c;
    logic               saturate_c;
    logic [DIGIT_W-1:0] inc_tens_c;
    logic [DIGIT_W-1:0] inc_ones_c;
    logic [DIGIT_W-1:0] tens_d;
    logic [DIGIT_W-1:0] ones_d;
    logic               better_c;

    // Count after this cycle's tick (if any), and whether the tick would saturate.
    always_comb begin
        at_max_c   = (tens_q == MAX_T) && (ones_q == MAX_O);
        saturate_c = tick && at_max_c;
        if (ones_q >= NINE) begin
            inc_ones_c = ZERO;
            inc_tens_c = (tens_q >= NINE) ? NINE : tens_q + DIGIT_W'(1);
        end else begin
            inc_ones_c = ones_q + DIGIT_W'(1);
            inc_tens_c = tens_q;
        end
        if (tick && !at_max_c) begin
            tens_d = inc_tens_c;
            ones_d = inc_ones_c;
        end else begin
            tens_d = tens_q;
            ones_d = ones_q;
        end
        better_c = !best_valid_q
                || (tens_d < best_tens_q)
                || ((tens_d == best_tens_q) && (ones_d < best_ones_q));
    end

    // Control FSM: clear > start > stop > tick; tick and stop in RUN combine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tens_q       <= ZERO;
            ones_q       <= ZERO;
            running_q    <= 1'b0;
            overflow_q   <= 1'b0;
            best_tens_q  <= NINE;
            best_ones_q  <= NINE;
            best_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear) begin
                        tens_q     <= ZERO;
                        ones_q     <= ZERO;
                        overflow_q <= 1'b0;
                    end else if (start) begin
                        state_q    <= S_RUN;
                        tens_q     <= ZERO;
                        ones_q     <= ZERO;
                        overflow_q <= 1'b0;
                        running_q  <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (clear) begin
                        state_q    <= S_IDLE;
                        tens_q     <= ZERO;
                        ones_q     <= ZERO;
                        overflow_q <= 1'b0;
                        running_q  <= 1'b0;
                    end else if (saturate_c) begin
                        state_q    <= S_HOLD;
                        overflow_q <= 1'b1;
                        running_q  <= 1'b0;
                    end else begin
                        tens_q <= tens_d;
                        ones_q <= ones_d;
                        if (stop) begin
                            state_q      <= S_HOLD;
                            running_q    <= 1'b0;
                            best_valid_q <= 1'b1;
                            if (better_c) begin
                                best_tens_q <= tens_d;
                                best_ones_q <= ones_d;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (clear) begin
                        state_q    <= S_IDLE;
                        tens_q     <= ZERO;
                        ones_q     <= ZERO;
                        overflow_q <= 1'b0;
                    end else if (start) begin
                        state_q    <= S_RUN;
                        tens_q     <= ZERO;
                        ones_q     <= ZERO;
                        overflow_q <= 1'b0;
                        running_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    tens_q     <= ZERO;
                    ones_q     <= ZERO;
                    overflow_q <= 1'b0;
                    running_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tens       = tens_q;
    assign ones       = ones_q;
    assign running    = running_q;
    assign overflow   = overflow_q;
    assign best_tens  = best_tens_q;
    assign best_ones  = best_ones_q;
    assign best_valid = best_valid_q;

endmodule

// File: tb/tb_reaction_timer_bcd.sv
// Self-checking bench: directed test-plan scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a count-based model.
module tb_reaction_timer_bcd;

    localparam int MAXV = 99;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] tens, ones, best_tens, best_ones;
    logic       running, overflow, best_valid;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: mode 0=idle 1=run 2=hold; count kept as a plain integer 0..99.
    int m_mode = 0;
    int m_cnt  = 0;
    int m_ovf  = 0;
    int m_best = 99;
    int m_bv   = 0;

    reaction_timer_bcd #(.MAX_TENS(9), .MAX_ONES(9)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop), .clear(clear),
        .tens(tens), .ones(ones), .running(running), .overflow(overflow),
        .best_tens(best_tens), .best_ones(best_ones), .best_valid(best_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_ovf = 0; m_best = 99; m_bv = 0;
        end else if (clear) begin
            m_mode = 0; m_cnt = 0; m_ovf = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_cnt = 0; m_ovf = 0;
            end
        end else if (tick && m_cnt == MAXV) begin
            m_mode = 2; m_ovf = 1;
        end else begin
            if (tick) m_cnt = m_cnt + 1;
            if (stop) begin
                m_mode = 2;
                if (m_bv == 0 || m_cnt < m_best) m_best = m_cnt;
                m_bv = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [18:0] got, exp;
            got = {tens, ones, running, overflow, best_tens, best_ones, best_valid};
            exp = {4'(m_cnt / 10), 4'(m_cnt % 10), m_mode == 1, m_ovf != 0,
                   4'(m_best / 10), 4'(m_best % 10), m_bv != 0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL model t=%0t got t/o=%0d/%0d run=%b ovf=%b best=%0d/%0d bv=%b exp cnt=%0d mode=%0d ovf=%0d best=%0d bv=%0d",
                         $time, tens, ones, running, overflow, best_tens, best_ones, best_valid,
                         m_cnt, m_mode, m_ovf, m_best, m_bv);
            end
        end
    end

    task automatic step(input logic st, input logic sp, input logic cl, input logic tk,
                        input logic rs = 1'b0);
        start = st; stop = sp; clear = cl; tick = tk; reset = rs;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0; tick = 1'b0; reset = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int t, input int o, input int r,
                           input int ov, input int bt, input int bo, input int bv);
        chk({name, ".tens"}, int'(tens), t);
        chk({name, ".ones"}, int'(ones), o);
        chk({name, ".running"}, int'(running), r);
        chk({name, ".overflow"}, int'(overflow), ov);
        chk({name, ".best_tens"}, int'(best_tens), bt);
        chk({name, ".best_ones"}, int'(best_ones), bo);
        chk({name, ".best_valid"}, int'(best_valid), bv);
    endtask

    initial begin
        // 1: reset then idle
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1);
        chk_all("idle", 0, 0, 0, 0, 9, 9, 0);

        // 2: run of 23, then clear
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_running", int'(running), 1);
        ticks(23);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("stop23", 2, 3, 0, 0, 2, 3, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("clear23", 0, 0, 0, 0, 2, 3, 1);

        // 3/4: carry, then saturation and restart
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(9);
        chk_all("nine", 0, 9, 1, 0, 2, 3, 1);
        ticks(1);
        chk_all("carry", 1, 0, 1, 0, 2, 3, 1);
        ticks(89);
        chk_all("t99", 9, 9, 1, 0, 2, 3, 1);
        ticks(1);
        chk_all("sat", 9, 9, 0, 1, 2, 3, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk_all("hold_frozen", 9, 9, 0, 1, 2, 3, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("restart", 0, 0, 1, 0, 2, 3, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // 5: best tracking
        step(1'b1, 1'b0, 1'b0, 1'b0); ticks(15); step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("best15", 1, 5, 0, 0, 1, 5, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0); ticks(40); step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("best40", 4, 0, 0, 0, 1, 5, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0); ticks(7); step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("best7", 0, 7, 0, 0, 0, 7, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0); ticks(2); step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("abort2", 0, 0, 0, 0, 0, 7, 1);

        // 6: stop+tick, clear+start in HOLD, reset mid-run
        step(1'b1, 1'b0, 1'b0, 1'b0); ticks(4); step(1'b0, 1'b1, 1'b0, 1'b1);
        chk_all("stop_tick", 0, 5, 0, 0, 0, 5, 1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("clear_start", 0, 0, 0, 0, 0, 5, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0); ticks(31);
        chk_all("pre_reset", 3, 1, 1, 0, 0, 5, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("reset_mid", 0, 0, 0, 0, 9, 9, 0);

        // Randomized traffic; start/stop kept exclusive, stops rarer later to reach saturation.
        for (int i = 0; i < 6000; i++) begin
            logic st, sp, cl, tk, rs;
            int sel, stop_div;
            stop_div = (i < 3000) ? 20 : 250;
            tk  = ($urandom_range(3, 0) != 0);
            sel = int'($urandom_range(999, 0));
            st  = (sel < 25);
            sp  = !st && ($urandom_range(stop_div - 1, 0) == 0);
            cl  = ($urandom_range(119, 0) == 0);
            rs  = ($urandom_range(1499, 0) == 0);
            step(st, sp, cl, tk, rs);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
